// File: rtl/memory_pkg.sv
// Shared definitions for the memory library: bank update modes and the
// address-width helpers used to size word selectors.
package memory_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_WRITE  = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    longint unsigned span;
    result = 0;
    span   = 1;
    while (span < longint'(value)) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int unsigned addr_bits(input int unsigned words);
    return (clog2(words) < 1) ? 1 : clog2(words);
  endfunction

endpackage

// File: rtl/register_bank_shift_uret_if.sv
// Control and status bundle of the register bank; the tri-stated read
// ports stay on the module boundary next to their output enable.
interface register_bank_shift_uret_if #(
  parameter int unsigned NrOfBits = 8,
  parameter int unsigned AddrBits = 2
);

  logic                ClockEnable;
  logic                Tick;
  logic [1:0]          Mode;
  logic [AddrBits-1:0] WrAddr;
  logic [NrOfBits-1:0] D;
  logic [AddrBits-1:0] RdAddrA;
  logic [AddrBits-1:0] RdAddrB;
  logic [NrOfBits-1:0] QTail;
  logic [AddrBits:0]   FillCount;
  logic                Full;

  modport master (
    output ClockEnable, Tick, Mode, WrAddr, D, RdAddrA, RdAddrB,
    input  QTail, FillCount, Full
  );

  modport slave (
    input  ClockEnable, Tick, Mode, WrAddr, D, RdAddrA, RdAddrB,
    output QTail, FillCount, Full
  );

endinterface

// File: rtl/fill_counter_sat.sv
// Saturating occupancy counter with asynchronous clear and asynchronous
// load-to-max; clear wins over load.
module fill_counter_sat #(
  parameter int unsigned MaxValue    = 4,
  parameter int unsigned Width       = 3,
  parameter int unsigned ActiveLevel = 1
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             load_max,
  input  logic             inc,
  output logic [Width-1:0] count,
  output logic             full
);

  localparam logic [Width-1:0] MaxCount = Width'(MaxValue);

  logic [Width-1:0] count_next;

  always_comb begin
    count_next = count;
    if (inc && (count != MaxCount)) begin
      count_next = count + 1'b1;
    end
  end

  generate
    if (ActiveLevel != 0) begin : g_rise
      always_ff @(posedge Clock or posedge clear or posedge load_max) begin
        if (clear)         count <= '0;
        else if (load_max) count <= MaxCount;
        else               count <= count_next;
      end
    end else begin : g_fall
      always_ff @(negedge Clock or posedge clear or posedge load_max) begin
        if (clear)         count <= '0;
        else if (load_max) count <= MaxCount;
        else               count <= count_next;
      end
    end
  endgenerate

  assign full = (count == MaxCount);

endmodule

// File: rtl/register_bank_shift_uret.sv
// Multi-word register bank with addressed write, shift-in and rotate,
// two combinational read ports and a saturating fill counter.
module register_bank_shift_uret
  import memory_pkg::*;
#(
  parameter int unsigned NrOfBits    = 8,
  parameter int unsigned NrOfWords   = 4,
  parameter int unsigned ActiveLevel = 1
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       pre,
  input  logic                       cs,
  register_bank_shift_uret_if.slave  bus,
  output logic [NrOfBits-1:0]        QA,
  output logic [NrOfBits-1:0]        QB
);

  localparam int unsigned AddrBits = addr_bits(NrOfWords);

  logic [NrOfBits-1:0] words      [NrOfWords];
  logic [NrOfBits-1:0] words_next [NrOfWords];
  logic [NrOfBits-1:0] rd_a;
  logic [NrOfBits-1:0] rd_b;
  logic                capture;
  mode_e               mode;

  assign capture = bus.ClockEnable & bus.Tick;
  assign mode    = mode_e'(bus.Mode);

  // Address compare per word: an out-of-range write address matches nothing.
  always_comb begin
    words_next = words;
    if (capture) begin
      case (mode)
        MODE_WRITE: begin
          for (int unsigned i = 0; i < NrOfWords; i++) begin
            if (bus.WrAddr == AddrBits'(i)) words_next[i] = bus.D;
          end
        end
        MODE_SHIFT: begin
          words_next[0] = bus.D;
          for (int unsigned i = 1; i < NrOfWords; i++) words_next[i] = words[i-1];
        end
        MODE_ROTATE: begin
          words_next[0] = words[NrOfWords-1];
          for (int unsigned i = 1; i < NrOfWords; i++) words_next[i] = words[i-1];
        end
        default: ;
      endcase
    end
  end

  generate
    if (ActiveLevel != 0) begin : g_rise
      always_ff @(posedge Clock or posedge Reset or posedge pre) begin
        for (int unsigned i = 0; i < NrOfWords; i++) begin
          if (Reset)    words[i] <= '0;
          else if (pre) words[i] <= '1;
          else          words[i] <= words_next[i];
        end
      end
    end else begin : g_fall
      always_ff @(negedge Clock or posedge Reset or posedge pre) begin
        for (int unsigned i = 0; i < NrOfWords; i++) begin
          if (Reset)    words[i] <= '0;
          else if (pre) words[i] <= '1;
          else          words[i] <= words_next[i];
        end
      end
    end
  endgenerate

  // Unmatched read addresses fall through to zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int unsigned i = 0; i < NrOfWords; i++) begin
      if (bus.RdAddrA == AddrBits'(i)) rd_a = words[i];
      if (bus.RdAddrB == AddrBits'(i)) rd_b = words[i];
    end
  end

  assign QA        = cs ? {NrOfBits{1'bz}} : rd_a;
  assign QB        = cs ? {NrOfBits{1'bz}} : rd_b;
  assign bus.QTail = words[NrOfWords-1];

  fill_counter_sat #(
    .MaxValue    (NrOfWords),
    .Width       (AddrBits + 1),
    .ActiveLevel (ActiveLevel)
  ) u_fill (
    .Clock    (Clock),
    .clear    (Reset),
    .load_max (pre),
    .inc      (capture && (mode == MODE_SHIFT)),
    .count    (bus.FillCount),
    .full     (bus.Full)
  );

endmodule
